frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the particle-buffer entry count (power of two, 2..16).
REQ-002 Parameter BG_COLOR, default 12'h000, sets the RGB444 background color written during clear.
REQ-003 clk_in  input  1  the single clock for the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  single-cycle pulse that requests a new frame.
REQ-006 p_valid  input  1  a particle record is offered.
REQ-007 p_ready  output  1  the block can accept a particle record.
REQ-008 p_x, p_y  input  6 each  particle top-left coordinate.
REQ-009 p_color  input  12  particle color, RGB444 {R[11:8],G[7:4],B[3:0]}.
REQ-010 p_last  input  1  marks the final particle of the frame.
REQ-011 write_en  output  1  pixel write strobe to the display pixel memory.
REQ-012 write_x, write_y  output  6 each  target pixel coordinate.
REQ-013 write_color  output  12  pixel color.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_done  output  1  single-cycle pulse when a frame has been completely written.

Function
REQ-016 A particle transfer SHALL occur on a rising clk_in edge where p_valid && p_ready; p_ready SHALL equal !fifo_full in every state, IDLE included.
REQ-017 The FIFO SHALL store {p_x, p_y, p_color, p_last}; a push and a pop in the same cycle SHALL both take effect; a record pushed in cycle N SHALL be poppable no earlier than cycle N+1.
REQ-018 The state machine SHALL have the states IDLE, CLEAR, FETCH, PLOT and DONE.
REQ-019 IDLE: frame_start SHALL move the block to CLEAR and zero the sweep counter; frame_start in any other state SHALL be ignored.
REQ-020 CLEAR: the block SHALL issue one write per cycle with BG_COLOR for all 4096 pixels, with x varying fastest, from (0,0) to (63,63); after (63,63) the next state SHALL be FETCH, for exactly 4096 CLEAR cycles.
REQ-021 FETCH: if the FIFO is non-empty, the block SHALL pop one record into working registers and go to PLOT; otherwise it SHALL stay in FETCH.
REQ-022 PLOT: the block SHALL spend exactly 4 cycles, with slot k=0..3 targeting (x+k[0], y+k[1]).
REQ-023 In PLOT, a slot whose coordinate exceeds 63 SHALL be clipped: the cycle is still consumed, write_en=0, and no wrap-around occurs.
REQ-024 After slot 3, the next state SHALL be DONE if the record had p_last=1, otherwise FETCH.
REQ-025 DONE SHALL last one cycle, assert frame_done for that cycle, and return to IDLE.
REQ-026 write_en, write_x, write_y and write_color SHALL be registered; they reflect the state and counters of the previous cycle, so there is one cycle of latency.
REQ-027 When write_en=0, write_x, write_y and write_color SHALL hold their last values.
REQ-028 Particles with p_last=0 pushed while the block is in IDLE SHALL remain queued and be drawn after the next clear.

Reset
REQ-029 While reset is high, the block SHALL clear these outputs and state on the next edge: state=IDLE, FIFO empty, write_en=0, write_x=0, write_y=0, write_color=0, frame_done=0, busy=0.
REQ-030 Reset asserted mid-CLEAR or mid-PLOT SHALL abort the frame, with no further writes and no frame_done.
REQ-031 p_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 A shared package display_pkg SHALL hold FB_W=64, FB_H=64, COLOR_W=12, the coordinate and color typedefs, and the fw_state_t enum.
REQ-033 The FIFO SHALL be a separate sub-module particle_fifo, with synchronous reset, a full and an empty flag, and no combinational path from push to pop.

Verification
REQ-034 Scenario: reset, then a frame_start pulse -> exactly 4096 writes of 12'h000, the first at (0,0) and the last at (63,63), followed by an idle FETCH.
REQ-035 Scenario: push (10,20,12'hF00,last=1) during CLEAR -> after the clear, writes to (10,20), (11,20), (10,21) and (11,21) with color F00, then a frame_done pulse 1 cycle after the last write.
REQ-036 Scenario: push (63,63,12'h0F0,last=1) -> exactly one write, to (63,63); the 3 clipped cycles still occur and frame_done follows.
REQ-037 Scenario: push 6 records back-to-back with FIFO_DEPTH=4 while in IDLE -> p_ready drops after 4 accepts, no record is lost or duplicated, and all are drawn in order.
REQ-038 Scenario: assert reset at clear pixel 2000 -> write_en=0 on the next cycle, busy=0, no frame_done, and a fresh frame_start restarts at (0,0).
REQ-039 Scenario: frame_start pulsed during PLOT -> ignored, so the current frame completes with a single frame_done and no second CLEAR.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display types: framebuffer geometry, pixel/color types,
// particle record layout and the frame writer state encoding.
package display_pkg;

  localparam int FB_W    = 64;
  localparam int FB_H    = 64;
  localparam int COLOR_W = 12;

  typedef logic [5:0]         coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    color_t color;
    logic   last;
  } particle_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    PLOT,
    DONE
  } fw_state_t;

endpackage

// File: rtl/particle_fifo.sv
// Particle record queue; flags come from registered pointers only,
// so a record pushed this cycle is visible to pop next cycle.
module particle_fifo
  import display_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_in,
  input  logic      reset,
  input  logic      push,
  input  particle_t din,
  output logic      full,
  input  logic      pop,
  output particle_t dout,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  particle_t        mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // extra pointer bit separates full from empty when indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Clears the framebuffer to a background color, then plots queued
// 2x2 particles with edge clipping; pixel writes are registered.
module frame_writer
  import display_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        p_valid,
  output logic        p_ready,
  input  logic [5:0]  p_x,
  input  logic [5:0]  p_y,
  input  logic [11:0] p_color,
  input  logic        p_last,
  output logic        write_en,
  output logic [5:0]  write_x,
  output logic [5:0]  write_y,
  output logic [11:0] write_color,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [11:0] SWEEP_END = 12'(FB_W * FB_H - 1);

  fw_state_t state, state_nxt;
  logic [11:0] sweep, sweep_nxt;
  logic [1:0]  slot, slot_nxt;
  particle_t   work, work_nxt;

  particle_t   fifo_din, fifo_dout;
  logic        fifo_full, fifo_empty, fifo_pop;

  logic        we_nxt, done_nxt;
  coord_t      x_nxt, y_nxt;
  color_t      col_nxt;
  logic [6:0]  px, py;

  assign fifo_din = '{x: p_x, y: p_y, color: p_color, last: p_last};
  assign p_ready  = !fifo_full;
  assign busy     = (state != IDLE);

  particle_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .push   (p_valid),
    .din    (fifo_din),
    .full   (fifo_full),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty)
  );

  // 7-bit sums so a slot past the right/bottom edge is detected, not wrapped
  assign px = {1'b0, work.x} + {6'd0, slot[0]};
  assign py = {1'b0, work.y} + {6'd0, slot[1]};

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    slot_nxt  = slot;
    work_nxt  = work;
    fifo_pop  = 1'b0;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    x_nxt     = write_x;
    y_nxt     = write_y;
    col_nxt   = write_color;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = CLEAR;
          sweep_nxt = '0;
        end
      end
      CLEAR: begin
        we_nxt    = 1'b1;
        x_nxt     = sweep[5:0];
        y_nxt     = sweep[11:6];
        col_nxt   = BG_COLOR;
        sweep_nxt = sweep + 12'd1;
        if (sweep == SWEEP_END) state_nxt = FETCH;
      end
      FETCH: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          work_nxt  = fifo_dout;
          slot_nxt  = '0;
          state_nxt = PLOT;
        end
      end
      PLOT: begin
        if (px < 7'(FB_W) && py < 7'(FB_H)) begin
          we_nxt  = 1'b1;
          x_nxt   = px[5:0];
          y_nxt   = py[5:0];
          col_nxt = work.color;
        end
        slot_nxt = slot + 2'd1;
        if (slot == 2'd3) state_nxt = work.last ? DONE : FETCH;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state       <= IDLE;
      sweep       <= '0;
      slot        <= '0;
      work        <= '0;
      write_en    <= 1'b0;
      write_x     <= '0;
      write_y     <= '0;
      write_color <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      sweep       <= sweep_nxt;
      slot        <= slot_nxt;
      work        <= work_nxt;
      write_en    <= we_nxt;
      write_x     <= x_nxt;
      write_y     <= y_nxt;
      write_color <= col_nxt;
      frame_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: handshake vector table, directed frames
// and random particle frames checked against a pixel-list model.
module tb_frame_writer;

  localparam logic [11:0] BG = 12'h000;

  logic        clk_in;
  logic        reset;
  logic        frame_start;
  logic        p_valid;
  logic        p_ready;
  logic [5:0]  p_x, p_y;
  logic [11:0] p_color;
  logic        p_last;
  logic        write_en;
  logic [5:0]  write_x, write_y;
  logic [11:0] write_color;
  logic        busy;
  logic        frame_done;

  frame_writer #(.FIFO_DEPTH(4), .BG_COLOR(BG)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .frame_start (frame_start),
    .p_valid     (p_valid),
    .p_ready     (p_ready),
    .p_x         (p_x),
    .p_y         (p_y),
    .p_color     (p_color),
    .p_last      (p_last),
    .write_en    (write_en),
    .write_x     (write_x),
    .write_y     (write_y),
    .write_color (write_color),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } wr_t;

  typedef struct {
    logic rst;
    logic fs;
    logic pv;
    logic e_rdy;
    logic e_busy;
    logic e_we;
  } vec_t;

  wr_t  got[$];
  wr_t  exp[$];
  int   done_q[$];
  int   cyc;
  int   n_acc;
  int   n_cmp;
  int   n_bad;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (write_en)
      got.push_back('{int'(write_x), int'(write_y), int'(write_color), cyc});
    if (frame_done) done_q.push_back(cyc);
    if (p_valid && p_ready) n_acc++;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // reference model: full-screen clear in raster order
  task automatic model_clear();
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 64; xx++)
        exp.push_back('{xx, yy, int'(BG), 0});
  endtask

  // reference model: 2x2 square, pixels past the edge are dropped
  task automatic model_part(int x, int y, int c);
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        if (x + dx < 64 && y + dy < 64)
          exp.push_back('{x + dx, y + dy, c, 0});
  endtask

  task automatic start_frame();
    got.delete();
    done_q.delete();
    frame_start = 1'b1;
    @(posedge clk_in);
    #1 frame_start = 1'b0;
  endtask

  task automatic push(int x, int y, int c, bit last);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    p_valid = 1'b1;
    p_x     = 6'(x);
    p_y     = 6'(y);
    p_color = 12'(c);
    p_last  = last;
    while (!ok && n < 6000) begin
      @(negedge clk_in);
      if (p_ready) ok = 1;
      n++;
    end
    @(posedge clk_in);
    #1 p_valid = 1'b0;
    if (!ok) chk("push accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(string nm);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < 9000) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    tick(10);
    chk({nm, " done pulses"}, done_q.size(), 1);
    chk({nm, " idle after"}, busy, 1'b0);
  endtask

  task automatic cmp_frame(string nm);
    int bad;
    bad = 0;
    chk({nm, " write count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i >= got.size()) bad++;
      else if (got[i].x != exp[i].x || got[i].y != exp[i].y ||
               got[i].c != exp[i].c) bad++;
    end
    chk({nm, " pixel errors"}, bad, 0);
  endtask

  // frame_done follows the last particle's first slot by 4 cycles
  task automatic chk_done_t(string nm, int idx);
    int t_req;
    int t_act;
    t_req = (got.size() > idx) ? got[idx].t + 4 : -1;
    t_act = (done_q.size() > 0) ? done_q[0] : -2;
    chk({nm, " done timing"}, t_act, t_req);
  endtask

  vec_t tbl[13];

  initial begin
    int idx;
    int np;
    int rx, ry, rc;
    n_cmp = 0;
    n_bad = 0;
    n_acc = 0;
    reset = 1'b1;
    frame_start = 1'b0;
    p_valid = 1'b0;
    p_x = '0;
    p_y = '0;
    p_color = '0;
    p_last = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    chk("rst write_en", write_en, 1'b0);
    chk("rst write_x", write_x, 6'd0);
    chk("rst write_y", write_y, 6'd0);
    chk("rst write_color", write_color, 12'd0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst p_ready", p_ready, 1'b1);

    // rst fs pv | ready busy we
    tbl[0]  = '{0, 0, 1, 1, 0, 0};
    tbl[1]  = '{0, 0, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 0, 0};
    tbl[3]  = '{0, 0, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 1, 1};
    tbl[11] = '{1, 0, 0, 1, 1, 1};
    tbl[12] = '{0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 13; i++) begin
      @(posedge clk_in);
      #1;
      reset       = tbl[i].rst;
      frame_start = tbl[i].fs;
      p_valid     = tbl[i].pv;
      @(negedge clk_in);
      chk($sformatf("vec%0d p_ready", i), p_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d write_en", i), write_en, tbl[i].e_we);
    end
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    frame_start = 1'b0;
    p_valid = 1'b0;
    tick(2);

    // plain clear, idle FETCH, then a corner particle
    exp.delete();
    model_clear();
    start_frame();
    tick(4096 + 20);
    cmp_frame("clear");
    chk("clear first x", got.size() > 0 ? got[0].x : -1, 0);
    chk("clear last y", got.size() > 0 ? got[got.size()-1].y : -1, 63);
    chk("fetch busy", busy, 1'b1);
    chk("fetch no done", done_q.size(), 0);
    idx = exp.size();
    model_part(63, 63, 12'h0F0);
    push(63, 63, 12'h0F0, 1);
    wait_done("corner");
    cmp_frame("corner");
    chk_done_t("corner", idx);
    chk("hold x", write_x, 6'd63);
    chk("hold y", write_y, 6'd63);
    chk("hold color", write_color, 12'h0F0);

    // particle pushed during clear
    exp.delete();
    model_clear();
    idx = exp.size();
    model_part(10, 20, 12'hF00);
    start_frame();
    tick(100);
    push(10, 20, 12'hF00, 1);
    wait_done("mid");
    cmp_frame("mid");
    chk_done_t("mid", idx);

    // six records with a four-deep queue, first four in IDLE
    exp.delete();
    model_clear();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) idx = exp.size();
      model_part(i * 7, 60 - i * 5, 12'h100 + i);
    end
    n_acc = 0;
    for (int i = 0; i < 4; i++) push(i * 7, 60 - i * 5, 12'h100 + i, 0);
    p_valid = 1'b1;
    p_x = 6'd28;
    p_y = 6'd40;
    p_color = 12'h104;
    p_last = 1'b0;
    @(negedge clk_in);
    chk("full p_ready", p_ready, 1'b0);
    tick(3);
    chk("full accepts", n_acc, 4);
    start_frame();
    push(28, 40, 12'h104, 0);
    push(35, 35, 12'h105, 1);
    wait_done("six");
    cmp_frame("six");
    chk_done_t("six", idx);
    chk("six accepts", n_acc, 6);

    // reset in the middle of the clear
    exp.delete();
    model_clear();
    start_frame();
    begin
      int n;
      n = 0;
      while (got.size() <= 2000 && n < 5000) begin
        @(negedge clk_in);
        #1;
        n++;
      end
    end
    reset = 1'b1;
    @(posedge clk_in);
    #1 reset = 1'b0;
    @(negedge clk_in);
    chk("abort write_en", write_en, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort pixel x", got.size() > 2000 ? got[2000].x : -1, 16);
    chk("abort pixel y", got.size() > 2000 ? got[2000].y : -1, 31);
    tick(20);
    chk("abort writes", got.size(), 2001);
    chk("abort no done", done_q.size(), 0);
    chk("abort p_ready", p_ready, 1'b1);
    exp.delete();
    model_clear();
    idx = exp.size();
    model_part(40, 63, 12'hABC);
    start_frame();
    tick(3);
    chk("restart x", got.size() > 0 ? got[0].x : -1, 0);
    chk("restart y", got.size() > 0 ? got[0].y : -1, 0);
    push(40, 63, 12'hABC, 1);
    wait_done("restart");
    cmp_frame("restart");
    chk_done_t("restart", idx);

    // frame_start during PLOT is ignored
    exp.delete();
    model_clear();
    idx = exp.size();
    model_part(5, 5, 12'h555);
    start_frame();
    tick(50);
    push(5, 5, 12'h555, 1);
    begin
      int n;
      n = 0;
      while (got.size() <= 4096 && n < 6000) begin
        @(negedge clk_in);
        #1;
        n++;
      end
    end
    frame_start = 1'b1;
    @(posedge clk_in);
    #1 frame_start = 1'b0;
    wait_done("plot fs");
    tick(20);
    cmp_frame("plot fs");
    chk_done_t("plot fs", idx);
    chk("plot fs busy", busy, 1'b0);

    // random particle frames
    for (int f = 0; f < 3; f++) begin
      exp.delete();
      model_clear();
      np = $urandom_range(1, 7);
      start_frame();
      for (int i = 0; i < np; i++) begin
        rx = ($urandom_range(0, 1) == 1) ? $urandom_range(60, 63)
                                         : $urandom_range(0, 63);
        ry = ($urandom_range(0, 1) == 1) ? $urandom_range(60, 63)
                                         : $urandom_range(0, 63);
        rc = $urandom_range(0, 4095);
        if (i == np - 1) idx = exp.size();
        model_part(rx, ry, rc);
        tick($urandom_range(0, 3));
        push(rx, ry, rc, i == np - 1);
      end
      wait_done($sformatf("rand%0d", f));
      cmp_frame($sformatf("rand%0d", f));
      chk_done_t($sformatf("rand%0d", f), idx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
